// File: rtl/reg_writeback.sv
// reg_writeback: single write-port initiator for the 16x16 register file.
// Merges a one-cycle ALU stream (A) with a buffered long-latency stream (B),
// tracks in-flight B destinations in a pending scoreboard, and exposes
// decode-stage hazard and bypass information.
module reg_writeback #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          a_valid,
    input  logic [ADDR_W-1:0]             a_reg,
    input  logic [DATA_W-1:0]             a_data,
    input  logic                          b_valid,
    input  logic [ADDR_W-1:0]             b_reg,
    input  logic [DATA_W-1:0]             b_data,
    output logic                          b_ready,
    input  logic                          pend_set,
    input  logic [ADDR_W-1:0]             pend_reg,
    input  logic [ADDR_W-1:0]             rd_reg1,
    input  logic [ADDR_W-1:0]             rd_reg2,
    output logic                          hazard,
    output logic                          fwd1_valid,
    output logic [DATA_W-1:0]             fwd1_data,
    output logic                          fwd2_valid,
    output logic [DATA_W-1:0]             fwd2_data,
    output logic                          reg_write,
    output logic [ADDR_W-1:0]             write_reg,
    output logic [DATA_W-1:0]             write_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          wb_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 1 << ADDR_W;

    // B-result buffer storage (contents are meaningless while count is zero)
    logic [ADDR_W-1:0] mem_reg_q  [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [NREG-1:0]   pend_q,   pend_d;
    logic              err_q,    err_d;
    logic              rw_q,     rw_d;
    logic [ADDR_W-1:0] wr_reg_q, wr_reg_d;
    logic [DATA_W-1:0] wd_q,     wd_d;

    logic              a_take;
    logic              full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              pend_take;
    logic [ADDR_W-1:0] head_reg;
    logic [DATA_W-1:0] head_data;

    // Handshake decode: zero-register traffic is accepted but produces no work
    always_comb begin
        a_take     = a_valid && (a_reg != '0);
        full       = (count_q == CNT_W'(FIFO_DEPTH));
        fifo_empty = (count_q == '0);
        push       = b_valid && !full && (b_reg != '0);
        pop        = !a_take && !fifo_empty;
        pend_take  = pend_set && (pend_reg != '0);
        head_reg   = mem_reg_q[rd_ptr_q];
        head_data  = mem_data_q[rd_ptr_q];
    end

    // Next-state for FIFO bookkeeping, scoreboard, error flag and write stage
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pend_d   = pend_q;
        err_d    = err_q;
        rw_d     = 1'b0;
        wr_reg_d = wr_reg_q;
        wd_d     = wd_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push && pop) count_d = count_q - CNT_W'(1);

        // A wins the write slot; the FIFO head only drains when A is idle
        if (a_take) begin
            rw_d     = 1'b1;
            wr_reg_d = a_reg;
            wd_d     = a_data;
        end else if (pop) begin
            rw_d     = 1'b1;
            wr_reg_d = head_reg;
            wd_d     = head_data;
        end

        // Clear first so a same-cycle set of the same register wins
        if (pop)       pend_d[head_reg] = 1'b0;
        if (pend_take) pend_d[pend_reg] = 1'b1;

        if (a_take && pend_q[a_reg])
            err_d = 1'b1;
        if (pend_take && pend_q[pend_reg] && !(pop && (head_reg == pend_reg)))
            err_d = 1'b1;
    end

    // Control and write-stage registers; reset discards everything immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pend_q   <= '0;
            err_q    <= 1'b0;
            rw_q     <= 1'b0;
            wr_reg_q <= '0;
            wd_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
            rw_q     <= rw_d;
            wr_reg_q <= wr_reg_d;
            wd_q     <= wd_d;
        end
    end

    // FIFO storage write on accepted push
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg_q[wr_ptr_q]  <= b_reg;
            mem_data_q[wr_ptr_q] <= b_data;
        end
    end

    // Decode-side hazard and bypass, plus registered write-port outputs
    always_comb begin
        b_ready    = !full;
        hazard     = ((rd_reg1 != '0) && pend_q[rd_reg1]) ||
                     ((rd_reg2 != '0) && pend_q[rd_reg2]);
        fwd1_valid = rw_q && (wr_reg_q == rd_reg1) && (rd_reg1 != '0);
        fwd2_valid = rw_q && (wr_reg_q == rd_reg2) && (rd_reg2 != '0);
        fwd1_data  = wd_q;
        fwd2_data  = wd_q;
        reg_write  = rw_q;
        write_reg  = wr_reg_q;
        write_data = wd_q;
        fifo_count = count_q;
        wb_err     = err_q;
    end

endmodule
